// File: rtl/sd_emmc_axi_pkg.sv
// Shared AXI constants and write-side FSM state type for the SD/eMMC DMA masters.
package sd_emmc_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } wr_state_t;

  // DMA bursts advance in 64-byte steps, so the low six address bits must be zero.
  function automatic logic burst_misaligned(input logic [5:0] addr_lo);
    return addr_lo != 6'd0;
  endfunction

endpackage

// File: rtl/sd_emmc_axi_wr_master.sv
// AXI4 write-burst master: one AW per DMA request, W beats drained from an FWFT FIFO,
// then a single B response; one burst outstanding at a time.
module sd_emmc_axi_wr_master
  import sd_emmc_axi_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     write_addr,
  input  logic                  addr_write_valid,
  output logic                  addr_write_ready,
  input  logic                  data_write_valid,
  output logic                  next_data_word,
  output logic                  w_last,
  input  logic [DATA_W-1:0]     fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  resp_err,
  output logic                  align_err,
  input  logic                  err_clr
);

  localparam int unsigned CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  wr_state_t         r_state;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [ADDR_W-1:0] r_awaddr;
  logic              r_awvalid;
  logic              r_w_last;
  logic              r_resp_err;
  logic              r_align_err;

  logic w_accept;
  logic w_aw_hs;
  logic w_wvalid;
  logic w_wlast;
  logic w_beat;
  logic w_b_hs;
  logic w_new_resp_err;
  logic w_new_align_err;

  // Address is taken only in IDLE; the DMA holds its request otherwise.
  assign w_accept = reset && (r_state == IDLE) && addr_write_valid;
  assign w_aw_hs  = r_awvalid && m_axi_awready;

  // FWFT head word goes straight onto the bus; a beat and a pop are the same event.
  assign w_wvalid = (r_state == DATA) && data_write_valid && !fifo_empty;
  assign w_wlast  = (r_state == DATA) && (r_beat_cnt == LAST_BEAT);
  assign w_beat   = w_wvalid && m_axi_wready;
  assign w_b_hs   = (r_state == RESP) && m_axi_bvalid;

  assign w_new_resp_err  = w_b_hs && (m_axi_bresp != AXI_RESP_OKAY);
  assign w_new_align_err = w_accept && burst_misaligned(write_addr[5:0]);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_w_last    <= 1'b0;
      r_resp_err  <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_w_last <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_awaddr  <= write_addr;
            r_awvalid <= 1'b1;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_beat) begin
            if (w_wlast) begin
              r_beat_cnt <= '0;
              r_state    <= RESP;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end
        RESP: begin
          if (w_b_hs) begin
            r_w_last <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      // A fresh error outranks a clear in the same cycle.
      r_resp_err  <= (r_resp_err && !err_clr) || w_new_resp_err;
      r_align_err <= (r_align_err && !err_clr) || w_new_align_err;
    end
  end

  assign addr_write_ready = w_accept;
  assign next_data_word   = w_beat;
  assign fifo_rd_en       = w_beat;
  assign w_last           = r_w_last;

  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = r_awvalid;

  assign m_axi_wdata  = fifo_dout;
  assign m_axi_wstrb  = {STRB_W{1'b1}};
  assign m_axi_wlast  = w_wlast;
  assign m_axi_wvalid = w_wvalid;

  assign m_axi_bready = (r_state == RESP);

  assign resp_err  = r_resp_err;
  assign align_err = r_align_err;

endmodule

// File: tb/tb_sd_emmc_axi_wr_master.sv
// Scoreboard bench for sd_emmc_axi_wr_master: AXI slave and FIFO models, expected AW/W queues.
module tb_sd_emmc_axi_wr_master;

  localparam int unsigned BURST_LEN = 16;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } w_exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] write_addr;
  logic        addr_write_valid;
  logic        addr_write_ready;
  logic        data_write_valid;
  logic        next_data_word;
  logic        w_last;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic        resp_err;
  logic        align_err;
  logic        err_clr;

  always #5 clock = ~clock;

  sd_emmc_axi_wr_master #(
    .ADDR_W(32), .DATA_W(32), .BURST_LEN(BURST_LEN)
  ) dut (
    .clock(clock), .reset(reset),
    .write_addr(write_addr), .addr_write_valid(addr_write_valid), .addr_write_ready(addr_write_ready),
    .data_write_valid(data_write_valid), .next_data_word(next_data_word), .w_last(w_last),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .resp_err(resp_err), .align_err(align_err), .err_clr(err_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_ndw   = 0;
  int n_wlast = 0;
  int n_pops  = 0;

  logic [31:0] exp_aw[$];
  w_exp_t      exp_w[$];

  int          cfg_aw_delay = 0;
  int          cfg_stall_at = -1;
  int          cfg_stall_len = 0;
  logic [1:0]  cfg_bresp = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FWFT FIFO model
  logic [31:0] fifo_mem [0:255];
  logic [7:0]  rd_ptr = 8'd0;
  logic [7:0]  wr_ptr = 8'd0;
  logic        fifo_flush = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_dout  = fifo_mem[rd_ptr];

  always @(posedge clock) begin
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      rd_ptr <= rd_ptr + 8'd1;
      n_pops <= n_pops + 1;
    end
  end

  // AXI slave model: configurable AW delay, one W stall window, B response after last beat
  initial begin : slave
    int   aw_cnt;
    int   w_beats;
    int   stall_cnt;
    logic w_hs;
    logic wl_hs;
    logic b_hs;
    aw_cnt = 0; w_beats = 0; stall_cnt = 0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    forever begin
      @(negedge clock);
      w_hs  = m_axi_wvalid && m_axi_wready;
      wl_hs = w_hs && m_axi_wlast;
      b_hs  = m_axi_bvalid && m_axi_bready;
      @(posedge clock);
      #1;
      if (!reset) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0;
        aw_cnt = 0; w_beats = 0; stall_cnt = 0;
      end else begin
        if (m_axi_awready) m_axi_awready = 1'b0;
        else if (m_axi_awvalid) begin
          if (aw_cnt >= cfg_aw_delay) begin
            m_axi_awready = 1'b1;
            aw_cnt = 0;
          end else aw_cnt++;
        end
        if (w_hs) w_beats++;
        if (b_hs) m_axi_bvalid = 1'b0;
        if (wl_hs) begin
          w_beats = 0; stall_cnt = 0;
          m_axi_bvalid = 1'b1; m_axi_bresp = cfg_bresp;
        end
        if (cfg_stall_at >= 0 && w_beats == cfg_stall_at && stall_cnt < cfg_stall_len) begin
          m_axi_wready = 1'b0;
          stall_cnt++;
        end else m_axi_wready = 1'b1;
      end
    end
  end

  // Monitor: pops expected AW/W entries on handshakes and checks protocol timing
  initial begin : monitor
    w_exp_t      e;
    logic [31:0] a;
    logic        prev_aw_stall, prev_w_stall, prev_b_hs, aw_seen;
    logic [31:0] prev_awaddr, prev_wdata;
    prev_aw_stall = 1'b0; prev_w_stall = 1'b0; prev_b_hs = 1'b0; aw_seen = 1'b0;
    prev_awaddr = '0; prev_wdata = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_aw_stall = 1'b0; prev_w_stall = 1'b0; prev_b_hs = 1'b0; aw_seen = 1'b0;
      end else begin
        if (fifo_empty) check("no_beat_when_empty", 32'({m_axi_wvalid, fifo_rd_en}), 32'd0);
        if (prev_aw_stall) begin
          check("aw_hold_valid", 32'(m_axi_awvalid), 32'd1);
          check("aw_hold_addr", m_axi_awaddr, prev_awaddr);
        end
        if (m_axi_awvalid && m_axi_awready) begin
          if (exp_aw.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL aw_unexpected: got awaddr 0x%0h expected no AW", m_axi_awaddr);
          end else begin
            a = exp_aw.pop_front();
            check("awaddr", m_axi_awaddr, a);
            check("awlen", 32'(m_axi_awlen), 32'd15);
            check("awsize", 32'(m_axi_awsize), 32'd2);
            check("awburst", 32'(m_axi_awburst), 32'd1);
          end
          aw_seen = 1'b1;
        end
        prev_aw_stall = m_axi_awvalid && !m_axi_awready;
        prev_awaddr   = m_axi_awaddr;

        if (prev_w_stall && m_axi_wvalid) check("wdata_hold", m_axi_wdata, prev_wdata);
        if (next_data_word || fifo_rd_en || (m_axi_wvalid && m_axi_wready))
          check("pop_eq_beat", 32'({next_data_word, fifo_rd_en}),
                32'({2{m_axi_wvalid && m_axi_wready}}));
        if (next_data_word) n_ndw++;
        if (m_axi_wvalid && m_axi_wready) begin
          check("w_after_aw", 32'(aw_seen), 32'd1);
          check("wstrb", 32'(m_axi_wstrb), 32'hF);
          if (exp_w.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL w_unexpected: got wdata 0x%0h expected no beat", m_axi_wdata);
          end else begin
            e = exp_w.pop_front();
            check("wdata", m_axi_wdata, e.data);
            check("wlast", 32'(m_axi_wlast), 32'(e.last));
          end
          if (m_axi_wlast) aw_seen = 1'b0;
        end
        prev_w_stall = m_axi_wvalid && !m_axi_wready;
        prev_wdata   = m_axi_wdata;

        if (w_last || prev_b_hs) check("w_last_after_b", 32'({w_last, prev_b_hs}), 32'd3);
        if (w_last) n_wlast++;
        prev_b_hs = m_axi_bvalid && m_axi_bready;
      end
    end
  end

  task automatic push_words(input logic [31:0] base, input int first, input int n);
    w_exp_t e;
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr] = base + 32'(i);
      e.data = base + 32'(i);
      e.last = ((first + i) == int'(BURST_LEN) - 1);
      exp_w.push_back(e);
      wr_ptr = wr_ptr + 8'd1;
    end
  endtask

  task automatic issue_req(input logic [31:0] addr, input logic clr);
    bit ok;
    ok = 0;
    exp_aw.push_back(addr);
    write_addr = addr; addr_write_valid = 1'b1; err_clr = clr;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (addr_write_ready) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL req_accept: got no addr_write_ready expected one within 100 cycles"); end
    @(posedge clock);
    #1;
    addr_write_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    int start;
    ok = 0; start = n_wlast;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (n_wlast != start) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s_done: got no w_last expected one within 400 cycles", name); end
    @(posedge clock);
    #1;
  endtask

  task automatic check_counts(input string name, input int ndw0, input int pops0, input int wl0);
    repeat (3) @(posedge clock);
    #1;
    check({name, "_ndw_count"}, 32'(n_ndw - ndw0), 32'd16);
    check({name, "_pop_count"}, 32'(n_pops - pops0), 32'd16);
    check({name, "_wlast_count"}, 32'(n_wlast - wl0), 32'd1);
  endtask

  task automatic run_burst(input string name, input logic [31:0] addr, input logic [31:0] base);
    int ndw0, pops0, wl0;
    ndw0 = n_ndw; pops0 = n_pops; wl0 = n_wlast;
    push_words(base, 0, 16);
    issue_req(addr, 1'b0);
    wait_done(name);
    check_counts(name, ndw0, pops0, wl0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clock);
    #1;
    err_clr = 1'b0;
    @(negedge clock);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected end before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  ndw0, pops0, wl0;
    bit  ok;
    reset = 1'b0; write_addr = '0; addr_write_valid = 1'b0; data_write_valid = 1'b0; err_clr = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    check("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
    check("rst_bready", 32'(m_axi_bready), 32'd0);
    check("rst_w_last", 32'(w_last), 32'd0);
    check("rst_ndw", 32'(next_data_word), 32'd0);
    check("rst_awaddr", m_axi_awaddr, 32'd0);
    check("rst_errs", 32'({resp_err, align_err}), 32'd0);
    check("rst_awready_out", 32'(addr_write_ready), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1; data_write_valid = 1'b1;
    @(posedge clock);
    #1;

    // 1: plain burst
    run_burst("t1_basic", 32'h1000_0040, 32'hA000_0000);
    check("t1_errs", 32'({resp_err, align_err}), 32'd0);

    // 2: wready low for 3 cycles on beat 5
    cfg_stall_at = 4; cfg_stall_len = 3;
    run_burst("t2_wstall", 32'h1000_0080, 32'hB000_0100);
    cfg_stall_at = -1; cfg_stall_len = 0;

    // 3: FIFO runs dry after 7 words
    ndw0 = n_ndw; pops0 = n_pops; wl0 = n_wlast;
    push_words(32'hC000_0200, 0, 7);
    issue_req(32'h1000_00C0, 1'b0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (fifo_empty) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL t3_drain: got FIFO not empty expected drained within 200 cycles"); end
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1;
    push_words(32'hC000_0207, 7, 9);
    wait_done("t3_empty");
    check_counts("t3_empty", ndw0, pops0, wl0);

    // 4: slow awready
    cfg_aw_delay = 10;
    run_burst("t4_awdelay", 32'h1000_0100, 32'hD000_0300);
    cfg_aw_delay = 0;

    // 5: error flags
    cfg_bresp = 2'b10;
    run_burst("t5_slverr", 32'h1000_0400, 32'h5000_0000);
    cfg_bresp = 2'b00;
    check("t5_resp_err_set", 32'(resp_err), 32'd1);
    check("t5_align_clean", 32'(align_err), 32'd0);
    pulse_clr();
    check("t5_resp_err_clr", 32'(resp_err), 32'd0);
    @(posedge clock);
    #1;
    run_burst("t5_misalign", 32'h1000_0104, 32'h5100_0000);
    check("t5_align_set", 32'(align_err), 32'd1);
    check("t5_resp_clean", 32'(resp_err), 32'd0);
    // clear and new misalignment in the same cycle: error stays
    wl0 = n_wlast;
    push_words(32'h5200_0000, 0, 16);
    issue_req(32'h1000_0208, 1'b1);
    @(negedge clock);
    check("t5_err_beats_clr", 32'(align_err), 32'd1);
    @(posedge clock);
    #1;
    wait_done("t5_clr_race");
    check("t5_clr_race_wlast", 32'(n_wlast - wl0), 32'd1);
    pulse_clr();
    check("t5_align_clr", 32'(align_err), 32'd0);
    @(posedge clock);
    #1;

    // 6: reset during beat 7 of a misaligned burst
    ndw0 = n_ndw;
    push_words(32'hE000_0000, 0, 16);
    issue_req(32'h3000_0010, 1'b0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (n_ndw - ndw0 == 6) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL t6_beats: got %0d beats expected 6 within 200 cycles", n_ndw - ndw0); end
    check("t6_align_before", 32'(align_err), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("t6_rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready}), 32'd0);
    check("t6_rst_pulses", 32'({w_last, next_data_word, fifo_rd_en}), 32'd0);
    check("t6_rst_awaddr", m_axi_awaddr, 32'd0);
    check("t6_rst_errs", 32'({resp_err, align_err}), 32'd0);
    @(posedge clock);
    #1;
    exp_w.delete();
    fifo_flush = 1'b1;
    @(posedge clock);
    #1;
    fifo_flush = 1'b0; reset = 1'b1;
    @(posedge clock);
    #1;
    run_burst("t6_after_rst", 32'h2000_0000, 32'hF000_0000);
    check("t6_errs_after", 32'({resp_err, align_err}), 32'd0);

    check("end_aw_queue_empty", 32'(exp_aw.size()), 32'd0);
    check("end_w_queue_empty", 32'(exp_w.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
